register_file_mp: RTL
=====================

REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rd_addr  input  NRD*ADDR_W  read addresses, port j at bits [j*ADDR_W +: ADDR_W].
REQ-009 SHALL have port rd_data  output  NRD*DATA_W  read data, same packing.
REQ-010 SHALL have port wr_en  input  NWR  per-port write enable.
REQ-011 SHALL have port wr_addr  input  NWR*ADDR_W  write addresses.
REQ-012 SHALL have port wr_data  input  NWR*DATA_W  write data.
REQ-013 SHALL have port sb_set_en  input  1  mark sb_set_addr busy (instruction issue).
REQ-014 SHALL have port sb_set_addr  input  ADDR_W  destination register being issued.
REQ-015 SHALL have port rd_busy  output  NRD  per-read-port pending-write flag.
REQ-016 SHALL have port wr_conflict  output  1  registered write-collision flag.

Function
REQ-017 SHALL store 2**ADDR_W words of DATA_W bits plus one busy bit per word.
REQ-018 SHALL write wr_data[i] into word wr_addr[i] on rising clk when wr_en[i]=1 and wr_addr[i]!=0.
REQ-019 SHALL hardwire word 0: reads return 0, writes ignored, busy bit never set, rd_busy 0.
REQ-020 SHALL resolve several enabled write ports to the same nonzero address by highest port index winning.
REQ-021 SHALL assert wr_conflict for exactly the one cycle after any such collision; collisions on address 0 SHALL not flag.
REQ-022 SHALL drive rd_data combinationally (zero-cycle latency) from the stored word when BYPASS=0; written value visible from the cycle after the write edge.
REQ-023 SHALL, when BYPASS=1, drive rd_data[j] with wr_data of the highest-index enabled port whose wr_addr equals nonzero rd_addr[j], else the stored word.
REQ-024 SHALL set busy[a] on rising clk when sb_set_en=1 and a=sb_set_addr!=0.
REQ-025 SHALL clear busy[a] on rising clk when any enabled write port targets a.
REQ-026 SHALL let set win over clear when set and clear hit the same address on the same edge (newer producer pending).
REQ-027 SHALL drive rd_busy[j] = busy[rd_addr[j]] when BYPASS=0; when BYPASS=1, rd_busy[j] SHALL be 0 if an enabled write port targets rd_addr[j] this cycle, else busy[rd_addr[j]].
REQ-028 SHALL treat all NRD read ports independently; identical read addresses return identical data and busy.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear every word to 0, every busy bit to 0, and wr_conflict to 0, independent of clk.
REQ-030 SHALL ignore writes and sb_set_en on any edge where rst_n=0; rd_data reads 0 for all addresses during reset (no bypass during reset).
REQ-031 SHALL resume normal operation on the first rising clk after rst_n deasserts; reset asserted mid-write SHALL leave the target word 0.

Verification
REQ-032 Reset then write port0 addr 1 = 0x12345678, read port1 addr 1 next cycle -> 0x12345678; read addr 0 -> 0x00000000.
REQ-033 Write port0 addr 0 = 0xFFAAFFAA -> rd_data for addr 0 stays 0, wr_conflict 0, rd_busy 0.
REQ-034 Same cycle: wr port0 addr 5 = 0xAAAA0000, wr port1 addr 5 = 0x0000BBBB -> stored 0x0000BBBB; with BYPASS=1 same-cycle read of 5 -> 0x0000BBBB; wr_conflict=1 next cycle only.
REQ-035 sb_set addr 7, then read 7 -> rd_busy=1; write addr 7 = 0x55 -> BYPASS=1 rd_busy=0 and rd_data=0x55 same cycle; after edge busy clear.
REQ-036 sb_set addr 9 and write addr 9 on same edge -> busy[9] remains 1 afterwards, word 9 holds written value.
REQ-037 Load addr 3 = 0xDEADBEEF, set busy 3, pulse rst_n low between edges -> word 3 reads 0 and rd_busy 0 immediately, without a clock edge.

Source files
------------

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with per-word busy scoreboard
// Highest-index write port wins on address collisions; word 0 is hardwired to zero.
module register_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  sb_set_en,
  input  logic [ADDR_W-1:0]     sb_set_addr,
  output logic [NRD-1:0]        rd_busy,
  output logic                  wr_conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0][DATA_W-1:0] mem_nxt;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busy_nxt;
  logic                         collision;

  // Ports are applied in ascending order so the highest index lands last;
  // the scoreboard set is applied after the clears so a newer producer stays pending.
  always_comb begin
    mem_nxt   = mem;
    busy_nxt  = busy;
    collision = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] != '0)) begin
        mem_nxt[wr_addr[i*ADDR_W +: ADDR_W]]  = wr_data[i*DATA_W +: DATA_W];
        busy_nxt[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    for (int i = 0; i < NWR; i++) begin
      for (int k = i + 1; k < NWR; k++) begin
        if (wr_en[i] && wr_en[k] &&
            (wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[k*ADDR_W +: ADDR_W]) &&
            (wr_addr[i*ADDR_W +: ADDR_W] != '0)) begin
          collision = 1'b1;
        end
      end
    end
    if (sb_set_en && (sb_set_addr != '0)) begin
      busy_nxt[sb_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem         <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      mem         <= mem_nxt;
      busy        <= busy_nxt;
      wr_conflict <= collision;
    end
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] data;
    logic              hit;

    assign ra = rd_addr[j*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem[ra];
      hit  = 1'b0;
      if ((BYPASS != 0) && (ra != '0)) begin
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == ra)) begin
            data = wr_data[i*DATA_W +: DATA_W];
            hit  = 1'b1;
          end
        end
      end
      if (ra == '0) begin
        data = '0;
      end
    end

    // Reset masks forwarding so every address reads zero while rst_n is low.
    assign rd_data[j*DATA_W +: DATA_W] = rst_n ? data : '0;
    assign rd_busy[j] = (ra != '0) && !hit && busy[ra];
  end

endmodule
